// File: rtl/tx_serializer_pkg.sv
// Shared types and constants for the tx_serializer slice.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package tx_serializer_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int FRAME_W = 20;
    localparam int CNT_W   = 5;

    // Bit-index landmarks inside a frame
    localparam logic [CNT_W-1:0] CNT_EN   = 5'd17;  // tx_en sample point
    localparam logic [CNT_W-1:0] CNT_PULL = 5'd18;  // gearbox pull point
    localparam logic [CNT_W-1:0] CNT_LAST = 5'd19;  // frame boundary

    // Additive scrambler x^7 + x^6 + 1, key taken from the MSB
    localparam int              LFSR_W    = 7;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'b110_0000;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h7F;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tx_lfsr.sv
// Scrambler key generator: 7-bit Fibonacci LFSR, one key bit per step.
// Latency: key_o reflects the current state; a step takes effect next cycle.
// Backpressure: none; the LFSR holds whenever step_i is low.
module tx_lfsr
    import tx_serializer_pkg::*;
(
    input  logic clk,
    input  logic res_n,
    input  logic step_i,
    input  logic load_i,
    output logic key_o
);

    logic [LFSR_W-1:0] lfsr_q;

    // Seed on reset or reload request, otherwise advance only when stepped
    always_ff @(posedge clk) begin
        if (!res_n || load_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (step_i) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign key_o = lfsr_q[LFSR_W-1];

endmodule

// File: rtl/tx_serializer.sv
// 20-bit word to 1-bit line serializer with idle training/fill; optional scrambler via TX_SERIALIZER_SCRAMBLE_EN.
// Latency: pull at end of cnt 18, word captured at the frame boundary, bit 0 on sdata the next cycle.
// Backpressure: never stalls the line; an empty gearbox at pull time yields one idle frame instead.
module tx_serializer
    import tx_serializer_pkg::*;
#(
    parameter logic [FRAME_W-1:0] IDLE_PATTERN = 20'h5F07C,
    parameter int                 SYNC_FRAMES  = 8
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               tx_en,
    input  logic               valid_in,
    input  logic [FRAME_W-1:0] data_in,
    output logic               shift_out,
    output logic               sdata,
    output logic               frame_start,
    output logic               link_up
);

    localparam logic [7:0] SYNC_LAST = 8'(SYNC_FRAMES - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [7:0]         sync_cnt_q;
    logic               en_q;
    logic               pulled_q;
    logic [FRAME_W-1:0] sh_q;
    logic               fs_q;
    logic               boundary;

    assign boundary = (cnt_q == CNT_LAST);
    assign cnt_d    = boundary ? '0 : cnt_q + 1'b1;

    // Pull request decoded purely from registers, no input feeds it
    assign shift_out = (state_q == ST_RUN) && (cnt_q == CNT_PULL) && en_q;

    // Frame counter, enable capture, pull record, link FSM and shift register
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            sync_cnt_q <= '0;
            en_q       <= 1'b0;
            pulled_q   <= 1'b0;
            sh_q       <= '0;
            fs_q       <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            fs_q  <= boundary;
            if (cnt_q == CNT_EN) begin
                en_q <= tx_en;
            end
            if (cnt_q == CNT_PULL) begin
                pulled_q <= shift_out && valid_in;
            end
            if (boundary) begin
                case (state_q)
                    ST_OFF: begin
                        if (en_q) begin
                            state_q    <= ST_SYNC;
                            sync_cnt_q <= '0;
                            sh_q       <= IDLE_PATTERN;
                        end else begin
                            sh_q <= '0;
                        end
                    end
                    ST_SYNC: begin
                        // The RUN entry frame is still idle; data starts one frame later
                        sh_q <= IDLE_PATTERN;
                        if (sync_cnt_q == SYNC_LAST) begin
                            state_q <= ST_RUN;
                        end else begin
                            sync_cnt_q <= sync_cnt_q + 8'd1;
                        end
                    end
                    ST_RUN: begin
                        // Disable suppressed the pull in this frame, so nothing is dropped
                        if (!en_q) begin
                            state_q <= ST_OFF;
                            sh_q    <= '0;
                        end else if (pulled_q) begin
                            sh_q <= data_in;
                        end else begin
                            sh_q <= IDLE_PATTERN;
                        end
                    end
                    default: begin
                        state_q <= ST_OFF;
                        sh_q    <= '0;
                    end
                endcase
            end else begin
                sh_q <= {1'b0, sh_q[FRAME_W-1:1]};
            end
        end
    end

    assign frame_start = fs_q;
    assign link_up     = (state_q == ST_RUN);

`ifdef TX_SERIALIZER_SCRAMBLE_EN
    logic data_frm_q;
    logic key;
    logic lfsr_load;

    // Reseed the keystream whenever training restarts
    assign lfsr_load = boundary && (state_q == ST_OFF) && en_q;

    // Flags frames carrying a pulled word; only those bits are scrambled
    always_ff @(posedge clk) begin
        if (!res_n) begin
            data_frm_q <= 1'b0;
        end else if (boundary) begin
            data_frm_q <= (state_q == ST_RUN) && en_q && pulled_q;
        end
    end

    tx_lfsr u_lfsr (
        .clk    (clk),
        .res_n  (res_n),
        .step_i (data_frm_q),
        .load_i (lfsr_load),
        .key_o  (key)
    );

    assign sdata = sh_q[0] ^ (key & data_frm_q);
`else
    assign sdata = sh_q[0];
`endif

endmodule

// File: tb/tb_tx_serializer.sv
// Frame-level bench for tx_serializer: table of per-frame stimulus/expectations plus a word scoreboard.
// Latency: each table row occupies exactly one 20-cycle frame.
// Backpressure: bench acts as the gearbox, presenting a word the cycle after each accepted pull.
module tb_tx_serializer;

    localparam logic [19:0] IDLE = 20'h5F07C;

    typedef enum int {K_ZERO, K_IDLE, K_DATA} kind_t;

    typedef struct {
        bit          en;    // tx_en level from cnt 10 of this frame
        bit          vld;   // valid_in level during this frame
        logic [19:0] word;  // word offered if pulled at cnt 18
        kind_t       kind;  // expected content of this frame on the line
        bit          fs;    // frame_start expected at cnt 0
        bit          lk;    // link_up expected throughout
        bit          pull;  // shift_out expected at cnt 18
    } vec_t;

    logic        clk;
    logic        res_n;
    logic        tx_en;
    logic        valid_in;
    logic [19:0] data_in;
    logic        shift_out;
    logic        sdata;
    logic        frame_start;
    logic        link_up;

    int          n_vec;
    int          n_bad;
    logic [19:0] exp_q[$];
    logic [6:0]  tb_lfsr;
    kind_t       prev_kind;
    vec_t        tbl[27];

    tx_serializer dut (
        .clk         (clk),
        .res_n       (res_n),
        .tx_en       (tx_en),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .shift_out   (shift_out),
        .sdata       (sdata),
        .frame_start (frame_start),
        .link_up     (link_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit en, bit vld, logic [19:0] w, kind_t k, bit fs, bit lk, bit p);
        vec_t v;
        v.en = en; v.vld = vld; v.word = w; v.kind = k; v.fs = fs; v.lk = lk; v.pull = p;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Keystream for one data frame; all zero when scrambling is compiled out
    task automatic gen_key(output logic [19:0] k);
        k = '0;
`ifdef TX_SERIALIZER_SCRAMBLE_EN
        for (int i = 0; i < 20; i++) begin
            k[i]    = tb_lfsr[6];
            tb_lfsr = {tb_lfsr[5:0], tb_lfsr[6] ^ tb_lfsr[5]};
        end
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at the negedge where cnt==0; consumes exactly one frame
    task automatic run_frame(input vec_t v);
        logic [19:0] got;
        logic [19:0] exp;
        logic [19:0] key;
        logic [19:0] w;
        int          fs_bad;
        int          so_bad;
        int          lk_bad;
        bit          pull_seen;
        got = '0; fs_bad = 0; so_bad = 0; lk_bad = 0; pull_seen = 0;
        if (prev_kind == K_ZERO && v.kind == K_IDLE) tb_lfsr = 7'h7F;
        for (int c = 0; c < 20; c++) begin
            got[c] = sdata;
            if (frame_start !== ((c == 0) && v.fs)) fs_bad++;
            if (link_up !== v.lk) lk_bad++;
            if (c == 18) begin
                if (shift_out !== v.pull) so_bad++;
                if (shift_out === 1'b1 && valid_in === 1'b1) begin
                    exp_q.push_back(v.word);
                    pull_seen = 1;
                end
            end else if (shift_out !== 1'b0) begin
                so_bad++;
            end
            if (c == 10) tx_en = v.en;
            valid_in = v.vld;
            if (c == 19 && pull_seen) data_in = v.word;
            else                      data_in = 20'($urandom);
            tick();
        end
        case (v.kind)
            K_ZERO:  exp = '0;
            K_IDLE:  exp = IDLE;
            default: begin
                exp = '0;
                if (exp_q.size() == 0) begin
                    check("data_available", 32'd0, 32'd1);
                end else begin
                    w = exp_q.pop_front();
                    gen_key(key);
                    exp = w ^ key;
                end
            end
        endcase
        check("frame_bits", {12'd0, got}, {12'd0, exp});
        check("frame_start_pulse", fs_bad, 0);
        check("link_up_level", lk_bad, 0);
        check("shift_out_timing", so_bad, 0);
        prev_kind = v.kind;
    endtask

    initial begin
        logic [19:0] got7;
        logic [19:0] w;
        logic [19:0] key;
        n_vec = 0; n_bad = 0;
        res_n = 1'b0; tx_en = 1'b1; valid_in = 1'b0; data_in = '0;
        prev_kind = K_ZERO; tb_lfsr = 7'h7F;

        tbl[0] = mk(1, 0, 20'h0,     K_ZERO, 0, 0, 0);
        for (int i = 1; i <= 8; i++) tbl[i] = mk(1, 0, 20'h0, K_IDLE, 1, 0, 0);
        tbl[9]  = mk(1, 1, 20'h00001, K_IDLE, 1, 1, 1);
        tbl[10] = mk(1, 1, 20'hABCDE, K_DATA, 1, 1, 1);
        tbl[11] = mk(1, 1, 20'hFFFFF, K_DATA, 1, 1, 1);
        tbl[12] = mk(1, 0, 20'h0,     K_DATA, 1, 1, 1);  // underflow at pull
        tbl[13] = mk(1, 1, 20'h00000, K_IDLE, 1, 1, 1);  // the one idle fill frame
        tbl[14] = mk(1, 1, 20'h3C3C3, K_DATA, 1, 1, 1);
        tbl[15] = mk(0, 1, 20'h0,     K_DATA, 1, 1, 0);  // disable at cnt 10
        tbl[16] = mk(0, 1, 20'h0,     K_ZERO, 1, 0, 0);
        tbl[17] = mk(1, 1, 20'h0,     K_ZERO, 1, 0, 0);  // re-enable
        for (int i = 18; i <= 25; i++) tbl[i] = mk(1, 1, 20'h0, K_IDLE, 1, 0, 0);
        tbl[26] = mk(1, 1, 20'h0F0F0, K_IDLE, 1, 1, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sdata", sdata, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_link_up", link_up, 0);
        check("rst_shift_out", shift_out, 0);
        res_n = 1'b1;

        for (int i = 0; i < 27; i++) run_frame(tbl[i]);

        // Mid-frame reset at cnt 7 of the data frame carrying 20'h0F0F0
        got7 = '0;
        for (int c = 0; c < 7; c++) begin
            got7[c] = sdata;
            if (c == 0) check("mid_frame_start", frame_start, 1);
            data_in = 20'($urandom);
            tick();
        end
        w = (exp_q.size() != 0) ? exp_q.pop_front() : 20'hDEAD0;
        gen_key(key);
        check("mid_partial_bits", {25'd0, got7[6:0]}, {25'd0, w[6:0] ^ key[6:0]});
        res_n = 1'b0; valid_in = 1'b0;
        tick();
        check("mid_rst_sdata", sdata, 0);
        check("mid_rst_frame_start", frame_start, 0);
        check("mid_rst_link_up", link_up, 0);
        check("mid_rst_shift_out", shift_out, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        res_n = 1'b1;
        prev_kind = K_ZERO; tb_lfsr = 7'h7F;

        // Full training must repeat after the reset
        for (int i = 0; i <= 8; i++) run_frame(tbl[i]);
        run_frame(mk(1, 0, 20'h0, K_IDLE, 1, 1, 1));

        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
